// File: rtl/arm_if_pkg.sv
// Shared definitions for the instruction-fetch stage.
package arm_if_pkg;

  localparam int WORD_W = 32;

  // AL-condition AND r0,r0,r0: the bubble word latched by IF/ID when no fetch is ready.
  localparam logic [WORD_W-1:0] NOP_INSTR = 32'hE000_0000;

  typedef enum logic [1:0] {
    ISSUE = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    KILL  = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: program counter, single-outstanding imem request and
// a one-word buffer presenting PC_out / instruction_out to the IF/ID register.
//
// state | meaning
// ------+---------------------------------------------------------------
// ISSUE | request pc this cycle unless stalled or redirected
// WAIT  | one request outstanding, response will be buffered
// HOLD  | buffered word presented (if_valid=1) until IF/ID takes it
// KILL  | one stale request outstanding, its response is discarded
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = arm_if_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        freeze,
  input  logic        mem_freeze,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PC_out,
  output logic [31:0] instruction_out,
  output logic        if_valid
);

  import arm_if_pkg::*;

  fetch_state_e      state_q, state_d;
  logic [WORD_W-1:0] pc_q, pc_d;
  logic [WORD_W-1:0] buf_q, buf_d;
  logic              valid_q, valid_d;
  logic              redirect;

  // A cache stall freezes the whole pipe, so it masks a branch redirect.
  assign redirect = branch_taken & ~mem_freeze;

  // State, pc and buffer registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ISSUE;
      pc_q    <= RESET_PC;
      buf_q   <= NOP_INSTR;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      buf_q   <= buf_d;
      valid_q <= valid_d;
    end
  end

  // Next-state, pc update and response capture.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    buf_d   = buf_q;
    valid_d = valid_q;
    unique case (state_q)
      ISSUE: begin
        if (!mem_freeze) begin
          if (branch_taken) begin
            pc_d = branch_addr;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        // Responses are accepted even under stall; only a redirect drops them.
        if (imem_ready && redirect) begin
          pc_d    = branch_addr;
          state_d = ISSUE;
        end else if (imem_ready) begin
          buf_d   = imem_rdata;
          valid_d = 1'b1;
          state_d = HOLD;
        end else if (redirect) begin
          pc_d    = branch_addr;
          state_d = KILL;
        end
      end
      HOLD: begin
        if (redirect) begin
          pc_d    = branch_addr;
          valid_d = 1'b0;
          state_d = ISSUE;
        end else if (!mem_freeze && !freeze) begin
          pc_d    = pc_q + 32'd4;
          valid_d = 1'b0;
          state_d = ISSUE;
        end
      end
      KILL: begin
        // Still exactly one response outstanding, even after a second redirect.
        if (redirect) begin
          pc_d = branch_addr;
        end
        if (imem_ready) begin
          state_d = ISSUE;
        end
      end
      default: begin
        state_d = ISSUE;
      end
    endcase
  end

  // Outputs come from registers; no rdata bypass. rst forces the bubble immediately.
  assign imem_req        = ~rst & (state_q == ISSUE) & ~mem_freeze & ~branch_taken;
  assign imem_addr       = pc_q;
  assign if_valid        = ~rst & valid_q;
  assign PC_out          = if_valid ? (pc_q + 32'd4) : 32'd0;
  assign instruction_out = if_valid ? buf_q : NOP_INSTR;

  // A response with nothing outstanding means the memory broke the one-request rule.
  a_no_orphan_response : assert property (
    @(posedge clk) disable iff (rst)
      !(imem_ready && ((state_q == ISSUE) || (state_q == HOLD)))
  );

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: latency-programmable memory model, a scoreboard of
// expected {PC_out, instruction} per delivered word, a vector table for plain
// sequential fetches and hand-written branch / stall / reset sequences.
module tb_if_fetch_unit;

  logic        clk;
  logic        rst;
  logic        freeze;
  logic        mem_freeze;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] PC_out;
  logic [31:0] instruction_out;
  logic        if_valid;

  localparam logic [31:0] NOP = 32'hE000_0000;

  if_fetch_unit dut (
    .clk             (clk),
    .rst             (rst),
    .freeze          (freeze),
    .mem_freeze      (mem_freeze),
    .branch_taken    (branch_taken),
    .branch_addr     (branch_addr),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ready      (imem_ready),
    .imem_rdata      (imem_rdata),
    .PC_out          (PC_out),
    .instruction_out (instruction_out),
    .if_valid        (if_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Request seen by the memory at each rising edge.
  logic        req_l;
  logic [31:0] addr_l;
  always @(posedge clk) begin
    req_l  <= imem_req;
    addr_l <= imem_addr;
  end

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  typedef struct {
    int          lat;
    int          frz;
    logic [31:0] addr;
    logic [31:0] pc;
    logic [31:0] instr;
  } vec_t;

  exp_t        exp_q[$];
  vec_t        vecs[5];
  int          n_checks;
  int          n_errs;
  int          lat;
  int          cnt;
  int          drops_req;
  int          drops_done;
  logic [31:0] pend_addr;
  logic        prev_v;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hE3A0_1005 ^ a;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Finish the current cycle: run the memory model and scoreboard just after
  // the rising edge, then return on the falling edge for the next stimulus.
  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    if (req_l) begin
      cnt       = lat;
      pend_addr = addr_l;
    end
    imem_ready = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    if (cnt > 0) begin
      cnt--;
      if (cnt == 0) begin
        imem_ready = 1'b1;
        imem_rdata = mem_word(pend_addr);
        if (drops_done < drops_req) begin
          drops_done++;
        end else begin
          e.pc    = pend_addr + 32'd4;
          e.instr = mem_word(pend_addr);
          exp_q.push_back(e);
        end
      end
    end
    if (if_valid && !prev_v) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errs++;
        $display("FAIL sb_underflow: got PC_out %h with no word expected", PC_out);
      end else begin
        e = exp_q.pop_front();
        chk("sb_pc", PC_out, e.pc);
        chk("sb_instr", instruction_out, e.instr);
      end
    end
    prev_v = if_valid;
    @(negedge clk);
  endtask

  task automatic wait_valid(input string name);
    int k;
    k = 0;
    while (!if_valid && k < 20) begin
      step();
      k++;
    end
    if (!if_valid) begin
      n_checks++;
      n_errs++;
      $display("FAIL %s: got no if_valid after %0d cycles, expected a fetched word", name, k);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish by 100000, expected end of test");
    $fatal(1);
  end

  initial begin
    int k;
    vecs[0] = '{lat: 1, frz: 0, addr: 32'h00, pc: 32'h04, instr: 32'hE3A0_1005};
    vecs[1] = '{lat: 1, frz: 3, addr: 32'h04, pc: 32'h08, instr: 32'hE3A0_1001};
    vecs[2] = '{lat: 2, frz: 0, addr: 32'h08, pc: 32'h0C, instr: 32'hE3A0_100D};
    vecs[3] = '{lat: 3, frz: 1, addr: 32'h0C, pc: 32'h10, instr: 32'hE3A0_1009};
    vecs[4] = '{lat: 1, frz: 0, addr: 32'h10, pc: 32'h14, instr: 32'hE3A0_1015};

    n_checks = 0; n_errs = 0;
    lat = 1; cnt = 0; drops_req = 0; drops_done = 0;
    pend_addr = '0; prev_v = 1'b0;
    rst = 1'b1; freeze = 1'b0; mem_freeze = 1'b0;
    branch_taken = 1'b0; branch_addr = '0;
    imem_ready = 1'b0; imem_rdata = '0;

    // Reset values
    repeat (3) step();
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(if_valid), 32'd0);
    chk("rst_pc_out", PC_out, 32'd0);
    chk("rst_instr", instruction_out, NOP);

    // Sequential fetches from reset, with varied latency and freeze in HOLD
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      lat = vecs[i].lat;
      #1;
      chk($sformatf("v%0d_req", i), 32'(imem_req), 32'd1);
      chk($sformatf("v%0d_addr", i), imem_addr, vecs[i].addr);
      k = 0;
      do begin
        step();
        k++;
      end while (!if_valid && k < 20);
      chk($sformatf("v%0d_latency", i), 32'(k), 32'(vecs[i].lat + 1));
      chk($sformatf("v%0d_pc", i), PC_out, vecs[i].pc);
      chk($sformatf("v%0d_instr", i), instruction_out, vecs[i].instr);
      if (vecs[i].frz > 0) begin
        freeze = 1'b1;
        for (int j = 0; j < vecs[i].frz; j++) begin
          step();
          chk($sformatf("v%0d_frz_valid", i), 32'(if_valid), 32'd1);
          chk($sformatf("v%0d_frz_pc", i), PC_out, vecs[i].pc);
          chk($sformatf("v%0d_frz_req", i), 32'(imem_req), 32'd0);
        end
        freeze = 1'b0;
      end
      step();
    end

    // Branch one cycle after a latency-4 request: stale word must be discarded
    chk("kill_req_addr", imem_addr, 32'h14);
    lat = 4;
    drops_req++;
    step();
    chk("kill_wait_req", 32'(imem_req), 32'd0);
    branch_taken = 1'b1;
    branch_addr  = 32'h100;
    step();
    branch_taken = 1'b0;
    k = 1;
    while (!imem_req && k < 10) begin
      chk("kill_valid", 32'(if_valid), 32'd0);
      chk("kill_instr", instruction_out, NOP);
      step();
      k++;
    end
    chk("kill_len", 32'(k), 32'd4);
    chk("kill_target", imem_addr, 32'h100);
    lat = 1;
    wait_valid("kill_fetch");
    chk("kill_fetch_pc", PC_out, 32'h104);
    step();

    // Branch and response in the same WAIT cycle: word dropped, no KILL visit
    chk("same_req_addr", imem_addr, 32'h104);
    lat = 1;
    drops_req++;
    step();
    branch_taken = 1'b1;
    branch_addr  = 32'h200;
    step();
    branch_taken = 1'b0;
    #1;
    chk("same_req", 32'(imem_req), 32'd1);
    chk("same_addr", imem_addr, 32'h200);
    chk("same_valid", 32'(if_valid), 32'd0);
    wait_valid("same_fetch");

    // mem_freeze together with branch in HOLD: everything holds, then branch applies
    mem_freeze   = 1'b1;
    branch_taken = 1'b1;
    branch_addr  = 32'h300;
    for (int j = 0; j < 2; j++) begin
      step();
      chk("mf_valid", 32'(if_valid), 32'd1);
      chk("mf_pc", PC_out, 32'h204);
      chk("mf_req", 32'(imem_req), 32'd0);
    end
    mem_freeze = 1'b0;
    step();
    branch_taken = 1'b0;
    #1;
    chk("mf_br_req", 32'(imem_req), 32'd1);
    chk("mf_br_addr", imem_addr, 32'h300);
    lat = 2;
    wait_valid("mf_fetch");
    step();

    // Reset while a latency-4 response is outstanding
    chk("rw_req_addr", imem_addr, 32'h304);
    lat = 4;
    drops_req++;
    step();
    rst = 1'b1;
    step();
    for (int j = 0; j < 4; j++) begin
      chk("rw_valid", 32'(if_valid), 32'd0);
      chk("rw_pc", PC_out, 32'd0);
      chk("rw_instr", instruction_out, NOP);
      chk("rw_req", 32'(imem_req), 32'd0);
      step();
    end
    rst = 1'b0;
    lat = 1;
    #1;
    chk("rw_req_after", 32'(imem_req), 32'd1);
    chk("rw_addr_after", imem_addr, 32'h0);
    wait_valid("rw_fetch");

    // pc wrap at the top of the address space
    branch_taken = 1'b1;
    branch_addr  = 32'hFFFF_FFFC;
    step();
    branch_taken = 1'b0;
    #1;
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    wait_valid("wrap_fetch");
    chk("wrap_pc_out", PC_out, 32'h0);
    chk("wrap_instr", instruction_out, 32'h1C5F_EFF9);
    step();
    chk("wrap_next_req", 32'(imem_req), 32'd1);
    chk("wrap_next_addr", imem_addr, 32'h0);

    chk("sb_leftover", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
